line_window_buffer: RTL and testbench

Parametrised multi-line ring buffer between the pixel stream and the convolution engine. Holds FILTER_SIZE+1 image lines of IMG_W pixels, accepts PIX_PER_WR pixels per beat under valid/ready flow control, and returns a full FILTER_SIZE×FILTER_SIZE window for any requested column in one read. One spare line lets the writer fill the next row while the engine still reads the current band.

---
 rtl/line_window_buffer_pkg.sv | 14 +
 rtl/line_window_buffer_if.sv | 38 +++
 rtl/line_window_buffer_line_ram.sv | 43 ++++
 rtl/line_window_buffer.sv | 122 ++++++++++++
 tb/tb_line_window_buffer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/line_window_buffer_pkg.sv
// Shared defaults for the line window buffer and the packing rule for window pixels.
// Pixel (row r, col c) of a KxK window lives at slot r*K+c of the packed window bus.
package line_window_buffer_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_IMG_W       = 28;
    localparam int DEF_FILTER_SIZE = 3;
    localparam int DEF_PIX_PER_WR  = 2;

    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// Write-stream and window-read signals between pixel source/engine and the line window buffer.
// master = pixel source plus convolution engine, slave = line_window_buffer.
interface line_window_buffer_if
    import line_window_buffer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int FILTER_SIZE = DEF_FILTER_SIZE,
    parameter int PIX_PER_WR  = DEF_PIX_PER_WR
);
    localparam int NUM_LINES = FILTER_SIZE + 1;
    localparam int CNT_W     = $clog2(NUM_LINES + 1);
    localparam int COL_W     = $clog2(IMG_W);

    logic                                     wr_valid;
    logic [PIX_PER_WR*DATA_W-1:0]             wr_data;
    logic                                     wr_ready;
    logic                                     line_done;
    logic                                     win_avail;
    logic [CNT_W-1:0]                         fill_cnt;
    logic                                     rd_en;
    logic [COL_W-1:0]                         rd_col;
    logic                                     rd_release;
    logic [FILTER_SIZE*FILTER_SIZE*DATA_W-1:0] rd_data;
    logic                                     rd_valid;
    logic                                     rd_err;

    modport master (
        output wr_valid, wr_data, rd_en, rd_col, rd_release,
        input  wr_ready, line_done, win_avail, fill_cnt, rd_data, rd_valid, rd_err
    );

    modport slave (
        input  wr_valid, wr_data, rd_en, rd_col, rd_release,
        output wr_ready, line_done, win_avail, fill_cnt, rd_data, rd_valid, rd_err
    );

endinterface

// File: rtl/line_window_buffer_line_ram.sv
// One image line: PIX_PER_WR-wide write port and a K-pixel read at any column.
// Latency: read data registered, valid one edge after re; output holds while re is low.
// Backpressure: none; the owner guarantees writes and reads stay in range.
module lwb_line_ram
    import line_window_buffer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int K          = DEF_FILTER_SIZE,
    parameter int PIX_PER_WR = DEF_PIX_PER_WR,
    parameter int COL_W      = $clog2(IMG_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [COL_W-1:0]             wr_col,
    input  logic [PIX_PER_WR*DATA_W-1:0] wr_data,
    input  logic                         re,
    input  logic [COL_W-1:0]             rd_col,
    output logic [K*DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int p = 0; p < PIX_PER_WR; p++) begin
                mem[wr_col + COL_W'(p)] <= wr_data[p*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (re) begin
            for (int c = 0; c < K; c++) begin
                rd_data[c*DATA_W +: DATA_W] <= mem[rd_col + COL_W'(c)];
            end
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Ring of FILTER_SIZE+1 line slots; returns a KxK window at any column for the oldest K lines.
// Latency: window and rd_valid one edge after an accepted rd_en; line_done on the last beat's edge.
// Backpressure: wr_ready low while every slot holds a complete line, until a release frees one.
module line_window_buffer
    import line_window_buffer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int FILTER_SIZE = DEF_FILTER_SIZE,
    parameter int PIX_PER_WR  = DEF_PIX_PER_WR
) (
    input  logic               clk,
    input  logic               rst,
    line_window_buffer_if.slave bus
);

    localparam int K          = FILTER_SIZE;
    localparam int NUM_LINES  = K + 1;
    localparam int CNT_W      = $clog2(NUM_LINES + 1);
    localparam int LINE_W     = $clog2(NUM_LINES);
    localparam int COL_W      = $clog2(IMG_W);
    localparam int LAST_COL   = IMG_W - PIX_PER_WR;
    localparam int MAX_RD_COL = IMG_W - K;

    logic [CNT_W-1:0]  fill_cnt;
    logic [LINE_W-1:0] head;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] rd_head;
    logic [COL_W-1:0]  wr_col;
    logic              line_done;
    logic              rd_valid;
    logic              rd_err;

    logic wr_ready, win_avail;
    logic wr_fire, wr_last;
    logic rel_ok, rel_bad, rd_ok, rd_bad;

    function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] l);
        return (l == LINE_W'(NUM_LINES - 1)) ? '0 : l + 1'b1;
    endfunction

    assign wr_ready  = fill_cnt < CNT_W'(NUM_LINES);
    assign win_avail = fill_cnt >= CNT_W'(K);
    assign wr_fire   = bus.wr_valid && wr_ready;
    assign wr_last   = wr_fire && (wr_col == COL_W'(LAST_COL));
    assign rel_ok    = bus.rd_release && win_avail;
    assign rel_bad   = bus.rd_release && !win_avail;
    assign rd_ok     = bus.rd_en && win_avail && (bus.rd_col <= COL_W'(MAX_RD_COL));
    assign rd_bad    = bus.rd_en && !rd_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt  <= '0;
            head      <= '0;
            wr_line   <= '0;
            wr_col    <= '0;
            rd_head   <= '0;
            line_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            line_done <= wr_last;
            rd_valid  <= rd_ok;
            rd_err    <= rd_bad || rel_bad;
            // The read samples the pre-release head, so a same-cycle release affects only later reads.
            if (rd_ok) rd_head <= head;
            if (wr_fire) wr_col <= wr_last ? '0 : wr_col + COL_W'(PIX_PER_WR);
            if (wr_last) wr_line <= next_line(wr_line);
            if (rel_ok) head <= next_line(head);
            case ({wr_last, rel_ok})
                2'b10:   fill_cnt <= fill_cnt + 1'b1;
                2'b01:   fill_cnt <= fill_cnt - 1'b1;
                default: fill_cnt <= fill_cnt;
            endcase
        end
    end

    logic [K*DATA_W-1:0] ram_q [NUM_LINES];

    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        lwb_line_ram #(
            .DATA_W     (DATA_W),
            .IMG_W      (IMG_W),
            .K          (K),
            .PIX_PER_WR (PIX_PER_WR),
            .COL_W      (COL_W)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .we      (wr_fire && (wr_line == LINE_W'(l))),
            .wr_col  (wr_col),
            .wr_data (bus.wr_data),
            .re      (rd_ok),
            .rd_col  (bus.rd_col),
            .rd_data (ram_q[l])
        );
    end

    logic [K*K*DATA_W-1:0] win;
    logic [LINE_W:0]       slot;

    always_comb begin
        win  = '0;
        slot = '0;
        for (int r = 0; r < K; r++) begin
            slot = {1'b0, rd_head} + (LINE_W + 1)'(r);
            if (slot >= (LINE_W + 1)'(NUM_LINES)) slot = slot - (LINE_W + 1)'(NUM_LINES);
            for (int c = 0; c < K; c++) begin
                win[win_idx(r, c, K)*DATA_W +: DATA_W] = ram_q[slot[LINE_W-1:0]][c*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.line_done = line_done;
    assign bus.win_avail = win_avail;
    assign bus.fill_cnt  = fill_cnt;
    assign bus.rd_data   = win;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_err    = rd_err;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: fill, backpressure, release, window reads and error pulses.
module tb_line_window_buffer;
    import line_window_buffer_pkg::*;

    localparam int K  = 3;
    localparam int W  = 28;
    localparam int P  = 2;
    localparam int DW = 8;
    localparam int WW = K * K * DW;
    localparam int BEATS = W / P;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_window_buffer_if bus();

    line_window_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    function automatic logic [7:0] pix(input int row, input int col);
        return 8'((row * W + col) % 256);
    endfunction

    function automatic logic [WW-1:0] exp_win(input int row0, input int col0);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[win_idx(r, c, K)*DW +: DW] = pix(row0 + r, col0 + c);
        return w;
    endfunction

    task automatic idle();
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_col     = '0;
        bus.rd_release = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int row, input int b);
        bus.wr_valid = 1'b1;
        for (int p = 0; p < P; p++) bus.wr_data[p*DW +: DW] = pix(row, b * P + p);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic send_line(input int row);
        for (int b = 0; b < BEATS; b++) beat(row, b);
    endtask

    task automatic test_reset();
        idle();
        #1;
        total++; if (bus.fill_cnt !== 3'd0) $display("FAIL reset_fill_cnt got %0d want 0", bus.fill_cnt); else passed++;
        total++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); else passed++;
        total++; if (bus.win_avail !== 1'b0) $display("FAIL reset_win_avail got %b want 0", bus.win_avail); else passed++;
        total++; if (bus.rd_data !== '0) $display("FAIL reset_rd_data got %h want 0", bus.rd_data); else passed++;
        total++; if ({bus.rd_valid, bus.rd_err, bus.line_done} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {bus.rd_valid, bus.rd_err, bus.line_done}); else passed++;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        send_line(9);
        beat(9, 0);
        bus.rd_en = 1'b1;
        beat(9, 1);
        bus.rd_en = 1'b0;
        total++; if (bus.fill_cnt !== 3'd1) $display("FAIL mid_pre_fill got %0d want 1", bus.fill_cnt); else passed++;
        total++; if (bus.rd_err !== 1'b1) $display("FAIL mid_pre_rd_err got %b want 1", bus.rd_err); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (bus.fill_cnt !== 3'd0) $display("FAIL mid_fill_cnt got %0d want 0", bus.fill_cnt); else passed++;
        total++; if (bus.wr_ready !== 1'b1) $display("FAIL mid_wr_ready got %b want 1", bus.wr_ready); else passed++;
        total++; if (bus.rd_err !== 1'b0) $display("FAIL mid_rd_err got %b want 0", bus.rd_err); else passed++;
        total++; if (bus.rd_data !== '0) $display("FAIL mid_rd_data got %h want 0", bus.rd_data); else passed++;
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_fill3();
        int tab[9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
        for (int row = 0; row < 3; row++) begin
            for (int b = 0; b < BEATS; b++) begin
                beat(row, b);
                total++; if (bus.line_done !== (b == BEATS - 1)) $display("FAIL fill_line_done row %0d beat %0d got %b", row, b, bus.line_done); else passed++;
            end
            total++; if (bus.fill_cnt !== 3'(row + 1)) $display("FAIL fill_cnt row %0d got %0d want %0d", row, bus.fill_cnt, row + 1); else passed++;
            total++; if (bus.win_avail !== (row == 2)) $display("FAIL fill_win_avail row %0d got %b", row, bus.win_avail); else passed++;
        end
        bus.rd_en = 1'b1; bus.rd_col = 5'd0;
        tick();
        bus.rd_en = 1'b0;
        total++; if (bus.rd_valid !== 1'b1) $display("FAIL rd0_valid got %b want 1", bus.rd_valid); else passed++;
        for (int i = 0; i < 9; i++) begin
            total++; if (bus.rd_data[i*DW +: DW] !== 8'(tab[i])) $display("FAIL rd0_pix %0d got %0d want %0d", i, bus.rd_data[i*DW +: DW], tab[i]); else passed++;
        end
        tick();
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL rd0_valid_pulse got %b want 0", bus.rd_valid); else passed++;
    endtask

    task automatic test_full();
        int tab[9] = '{53, 54, 55, 81, 82, 83, 109, 110, 111};
        send_line(3);
        total++; if (bus.fill_cnt !== 3'd4) $display("FAIL full_fill got %0d want 4", bus.fill_cnt); else passed++;
        total++; if (bus.wr_ready !== 1'b0) $display("FAIL full_wr_ready got %b want 0", bus.wr_ready); else passed++;
        bus.wr_valid = 1'b1; bus.wr_data = 16'hEEEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.line_done !== 1'b0 || bus.fill_cnt !== 3'd4) $display("FAIL full_ignore cyc %0d got ld %b fill %0d want 0/4", i, bus.line_done, bus.fill_cnt); else passed++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        total++; if (bus.fill_cnt !== 3'd3) $display("FAIL rel_fill got %0d want 3", bus.fill_cnt); else passed++;
        total++; if (bus.wr_ready !== 1'b1) $display("FAIL rel_wr_ready got %b want 1", bus.wr_ready); else passed++;
        send_line(4);
        total++; if (bus.fill_cnt !== 3'd4) $display("FAIL line5_fill got %0d want 4", bus.fill_cnt); else passed++;
        bus.rd_en = 1'b1; bus.rd_col = 5'd25;
        tick();
        bus.rd_en = 1'b0;
        total++; if (bus.rd_valid !== 1'b1) $display("FAIL rd25_valid got %b want 1", bus.rd_valid); else passed++;
        for (int i = 0; i < 9; i++) begin
            total++; if (bus.rd_data[i*DW +: DW] !== 8'(tab[i])) $display("FAIL rd25_pix %0d got %0d want %0d", i, bus.rd_data[i*DW +: DW], tab[i]); else passed++;
        end
    endtask

    task automatic test_rd_err();
        bus.rd_en = 1'b1; bus.rd_col = 5'd26;
        tick();
        bus.rd_en = 1'b0;
        total++; if (bus.rd_err !== 1'b1) $display("FAIL col26_rd_err got %b want 1", bus.rd_err); else passed++;
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL col26_rd_valid got %b want 0", bus.rd_valid); else passed++;
        total++; if (bus.rd_data !== exp_win(1, 25)) $display("FAIL col26_hold got %h want %h", bus.rd_data, exp_win(1, 25)); else passed++;
        tick();
        total++; if (bus.rd_err !== 1'b0) $display("FAIL col26_err_pulse got %b want 0", bus.rd_err); else passed++;
        bus.rd_release = 1'b1;
        tick();
        tick();
        bus.rd_release = 1'b0;
        total++; if (bus.fill_cnt !== 3'd2 || bus.rd_err !== 1'b0) $display("FAIL rel2 got fill %0d err %b want 2/0", bus.fill_cnt, bus.rd_err); else passed++;
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        total++; if (bus.rd_err !== 1'b1) $display("FAIL bad_rel_err got %b want 1", bus.rd_err); else passed++;
        total++; if (bus.fill_cnt !== 3'd2) $display("FAIL bad_rel_fill got %0d want 2", bus.fill_cnt); else passed++;
        bus.rd_en = 1'b1; bus.rd_col = 5'd0;
        tick();
        bus.rd_en = 1'b0;
        total++; if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) $display("FAIL noavail_rd got err %b vld %b want 1/0", bus.rd_err, bus.rd_valid); else passed++;
    endtask

    task automatic test_release_on_last();
        send_line(5);
        total++; if (bus.fill_cnt !== 3'd3) $display("FAIL rol_pre_fill got %0d want 3", bus.fill_cnt); else passed++;
        for (int b = 0; b < BEATS - 1; b++) beat(6, b);
        bus.rd_release = 1'b1;
        beat(6, BEATS - 1);
        bus.rd_release = 1'b0;
        total++; if (bus.line_done !== 1'b1) $display("FAIL rol_line_done got %b want 1", bus.line_done); else passed++;
        total++; if (bus.fill_cnt !== 3'd3) $display("FAIL rol_fill got %0d want 3", bus.fill_cnt); else passed++;
        total++; if (bus.rd_err !== 1'b0) $display("FAIL rol_rd_err got %b want 0", bus.rd_err); else passed++;
        bus.rd_en = 1'b1; bus.rd_col = 5'd0;
        tick();
        bus.rd_en = 1'b0;
        total++; if (bus.rd_data !== exp_win(4, 0)) $display("FAIL rol_window got %h want %h", bus.rd_data, exp_win(4, 0)); else passed++;
        send_line(7);
        total++; if (bus.fill_cnt !== 3'd4 || bus.wr_ready !== 1'b0) $display("FAIL rol_next_line got fill %0d rdy %b want 4/0", bus.fill_cnt, bus.wr_ready); else passed++;
    endtask

    task automatic test_rd_and_release();
        bus.rd_en = 1'b1; bus.rd_col = 5'd10; bus.rd_release = 1'b1;
        tick();
        bus.rd_en = 1'b0; bus.rd_release = 1'b0;
        total++; if (bus.rd_valid !== 1'b1) $display("FAIL rr_valid got %b want 1", bus.rd_valid); else passed++;
        total++; if (bus.rd_data !== exp_win(4, 10)) $display("FAIL rr_old_head got %h want %h", bus.rd_data, exp_win(4, 10)); else passed++;
        total++; if (bus.fill_cnt !== 3'd3) $display("FAIL rr_fill got %0d want 3", bus.fill_cnt); else passed++;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        total++; if (bus.rd_data !== exp_win(5, 10)) $display("FAIL rr_new_head got %h want %h", bus.rd_data, exp_win(5, 10)); else passed++;
    endtask

    task automatic test_back_to_back();
        int cols[5] = '{0, 1, 2, 3, 25};
        bus.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rd_col = 5'(cols[i]);
            tick();
            total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_win(5, cols[i])) $display("FAIL b2b col %0d got vld %b data %h want %h", cols[i], bus.rd_valid, bus.rd_data, exp_win(5, cols[i])); else passed++;
        end
        bus.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_full();
        send_line(8);
        total++; if (bus.wr_ready !== 1'b0) $display("FAIL rf_pre_rdy got %b want 0", bus.wr_ready); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (bus.wr_ready !== 1'b1 || bus.fill_cnt !== 3'd0 || bus.win_avail !== 1'b0) $display("FAIL rf_reset got rdy %b fill %0d avail %b want 1/0/0", bus.wr_ready, bus.fill_cnt, bus.win_avail); else passed++;
        total++; if (bus.rd_data !== '0) $display("FAIL rf_rd_data got %h want 0", bus.rd_data); else passed++;
        #1 rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_fill3();
        test_full();
        test_rd_err();
        test_release_on_last();
        test_rd_and_release();
        test_back_to_back();
        test_reset_full();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
